// File: rtl/lbist_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared constants for the LBIST session sequencer and the ORA datapath:
//   - default widths (CUT output, signature address, pattern and fault counters)
//   - 3-bit FSM state encoding of lbist_ctrl
// Optional build macro used by lbist_ctrl: LBIST_FAIL_STOP_EN.
// -----------------------------------------------------------------------------
package lbist_pkg;

    // Default widths, kept in one place so the ORA and the sequencer agree.
    localparam int OP_WIDTH        = 4;
    localparam int IP_SIG_ADD_BITS = 4;
    localparam int PAT_CNT_BITS    = 8;
    localparam int FAULT_CNT_BITS  = 4;

    // Sequencer state encoding (legacy-compatible 3-bit constants).
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] CMP   = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

endpackage

// File: rtl/lbist_sat_counter.sv
// -----------------------------------------------------------------------------
// lbist_sat_counter
// Saturating up-counter with synchronous clear (clear wins over enable).
// Used for the failed-session count; also suits the ORA detected-fault count.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   clr    in   synchronous clear to zero
//   en     in   count up by one, sticking at all-ones
//   count  out  WIDTH-bit registered count
// -----------------------------------------------------------------------------
module lbist_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count register: clear, saturating increment, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/lbist_ctrl.sv
// -----------------------------------------------------------------------------
// lbist_ctrl
// LBIST session sequencer. Per session: load TPG seed and clear the result
// compressor, run P patterns, flush the last response, strobe the comparator
// at the session's signature address, wait for its verdict and count fails.
// Build option: LBIST_FAIL_STOP_EN -- stop at the first failing session and
// keep its address on sig_add.
// Ports:
//   clk, rst        clock (rising) and asynchronous active-high reset
//   start           run request, honoured in IDLE and DONE only
//   num_sessions    sessions minus one (N runs N+1 sessions)
//   num_patterns    patterns per session, 0 means 2^PAT_CNT_BITS
//   cmp_valid/fail  comparator verdict, looked at only in WAIT
//   tpg_load/tpg_en pattern generator seed load / advance
//   rc_clr/rc_en    result compressor clear / compress
//   sig_add         signature address = current session index
//   cmp_req         one-cycle comparator strobe
//   busy/done/pass  run status; pass valid in DONE
//   fault_cnt       saturating count of failed sessions
// -----------------------------------------------------------------------------
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int IP_SIG_ADD_BITS = lbist_pkg::IP_SIG_ADD_BITS,
    parameter int PAT_CNT_BITS    = lbist_pkg::PAT_CNT_BITS,
    parameter int FAULT_CNT_BITS  = lbist_pkg::FAULT_CNT_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [IP_SIG_ADD_BITS-1:0] num_sessions,
    input  logic [PAT_CNT_BITS-1:0]    num_patterns,
    input  logic                       cmp_valid,
    input  logic                       cmp_fail,
    output logic                       tpg_load,
    output logic                       tpg_en,
    output logic                       rc_clr,
    output logic                       rc_en,
    output logic [IP_SIG_ADD_BITS-1:0] sig_add,
    output logic                       cmp_req,
    output logic                       busy,
    output logic                       done,
    output logic [FAULT_CNT_BITS-1:0]  fault_cnt,
    output logic                       pass
);

    logic [2:0]                 state_r,   state_s;
    logic [PAT_CNT_BITS-1:0]    pat_cnt_r, pat_cnt_s;
    logic [IP_SIG_ADD_BITS-1:0] sess_r,    sess_s;
    logic [IP_SIG_ADD_BITS-1:0] n_sess_r,  n_sess_s;
    logic [PAT_CNT_BITS-1:0]    n_pat_r,   n_pat_s;
    logic                       fault_clr_s;
    logic                       fault_inc_s;
    logic                       tpg_load_s, tpg_en_s, rc_clr_s, rc_en_s;
    logic                       cmp_req_s, busy_s, done_s, pass_s;

    // Next-state, counter and latch logic of the session sequencer.
    always_comb begin
        state_s     = state_r;
        pat_cnt_s   = pat_cnt_r;
        sess_s      = sess_r;
        n_sess_s    = n_sess_r;
        n_pat_s     = n_pat_r;
        fault_clr_s = 1'b0;
        fault_inc_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s     = LOAD;
                    sess_s      = '0;
                    n_sess_s    = num_sessions;
                    n_pat_s     = num_patterns;
                    fault_clr_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                state_s   = RUN;
                pat_cnt_s = n_pat_r;
            end
            RUN: begin
                // A loaded 0 wraps through all-ones, giving 2^PAT_CNT_BITS cycles.
                pat_cnt_s = pat_cnt_r - PAT_CNT_BITS'(1);
                if (pat_cnt_r == PAT_CNT_BITS'(1)) begin
                    state_s = FLUSH;
                end else begin
                    state_s = RUN;
                end
            end
            FLUSH: begin
                state_s = CMP;
            end
            CMP: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (cmp_valid) begin
                    fault_inc_s = cmp_fail;
`ifdef LBIST_FAIL_STOP_EN
                    if (cmp_fail || (sess_r == n_sess_r)) begin
`else
                    if (sess_r == n_sess_r) begin
`endif
                        state_s = DONE;
                    end else begin
                        state_s = LOAD;
                        sess_s  = sess_r + IP_SIG_ADD_BITS'(1);
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Moore output decode from the next state, so outputs are registered
    // yet line up with the cycle spent in that state.
    always_comb begin
        tpg_load_s = (state_s == LOAD);
        rc_clr_s   = (state_s == LOAD);
        tpg_en_s   = (state_s == RUN);
        rc_en_s    = (state_s == RUN) || (state_s == FLUSH);
        cmp_req_s  = (state_s == CMP);
        busy_s     = (state_s != IDLE) && (state_s != DONE);
        done_s     = (state_s == DONE);
        // Counter is zero next cycle only if zero now and not incrementing.
        pass_s     = done_s && (fault_cnt == '0) && !fault_inc_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            pat_cnt_r <= '0;
            sess_r    <= '0;
            n_sess_r  <= '0;
            n_pat_r   <= '0;
            tpg_load  <= 1'b0;
            tpg_en    <= 1'b0;
            rc_clr    <= 1'b0;
            rc_en     <= 1'b0;
            cmp_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state_r   <= state_s;
            pat_cnt_r <= pat_cnt_s;
            sess_r    <= sess_s;
            n_sess_r  <= n_sess_s;
            n_pat_r   <= n_pat_s;
            tpg_load  <= tpg_load_s;
            tpg_en    <= tpg_en_s;
            rc_clr    <= rc_clr_s;
            rc_en     <= rc_en_s;
            cmp_req   <= cmp_req_s;
            busy      <= busy_s;
            done      <= done_s;
            pass      <= pass_s;
        end
    end

    assign sig_add = sess_r;

    lbist_sat_counter #(
        .WIDTH (FAULT_CNT_BITS)
    ) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (fault_clr_s),
        .en    (fault_inc_s),
        .count (fault_cnt)
    );

endmodule
